mdp3_book_builder: RTL and testbench

MDP3_BOOK_BUILDER -- requirements
Module: mdp3_book_builder

---
 rtl/mdp3_book_builder.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mdp3_book_builder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdp3_book_builder.sv
// Single-instrument MDP3 price-level book: bids descending, asks ascending, DEPTH levels per side.
// Optional macro BOOK_SECURITY_FILTER_EN drops messages whose SECURITY_ID differs from TRACKED_SECURITY_ID.
module mdp3_book_builder #(
    parameter int          DEPTH               = 4,
    parameter logic [31:0] TRACKED_SECURITY_ID = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        message_ready,
    input  logic        enable_order_book,
    input  logic [7:0]  NUM_ORDERS,
    input  logic [15:0] QUANTITY,
    input  logic [63:0] PRICE,
    input  logic [1:0]  ACTION,
    input  logic [1:0]  ENTRY_TYPE,
    input  logic [31:0] SECURITY_ID,
    output logic [63:0] TOP_BID_PRICE,
    output logic [15:0] TOP_BID_QTY,
    output logic [63:0] TOP_ASK_PRICE,
    output logic [15:0] TOP_ASK_QTY,
    output logic [3:0]  bid_count,
    output logic [3:0]  ask_count,
    output logic        book_busy,
    output logic        book_updated,
    output logic        dropped,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, COMMIT} state_t;
    typedef enum logic [1:0] {OP_OVERWRITE, OP_INSERT, OP_REMOVE} op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic        msg_prev_q, msg_prev_d;
    logic        side_q, side_d;
    logic [1:0]  act_q, act_d;
    logic [63:0] price_cap_q, price_cap_d;
    logic [15:0] qty_cap_q, qty_cap_d;
    logic [7:0]  ord_cap_q, ord_cap_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  ptr_q, ptr_d;

    logic [63:0] price_q [2][DEPTH];
    logic [63:0] price_d [2][DEPTH];
    logic [15:0] qty_q   [2][DEPTH];
    logic [15:0] qty_d   [2][DEPTH];
    logic [7:0]  ord_q   [2][DEPTH];
    logic [7:0]  ord_d   [2][DEPTH];
    logic [3:0]  cnt_q   [2];
    logic [3:0]  cnt_d   [2];

    logic [63:0] top_bid_price_q, top_bid_price_d;
    logic [15:0] top_bid_qty_q, top_bid_qty_d;
    logic [63:0] top_ask_price_q, top_ask_price_d;
    logic [15:0] top_ask_qty_q, top_ask_qty_d;
    logic        updated_q, updated_d;
    logic        dropped_q, dropped_d;
    logic        overrun_q, overrun_d;

    logic        rise;
    logic        sec_reject;
    logic        hit;
    logic [3:0]  hit_idx;
    logic [3:0]  better;
    logic        full;
    logic [3:0]  last_idx;

`ifdef BOOK_SECURITY_FILTER_EN
    assign sec_reject = (SECURITY_ID != TRACKED_SECURITY_ID);
`else
    logic unused_security;
    assign unused_security = ^{SECURITY_ID, TRACKED_SECURITY_ID};
    assign sec_reject = 1'b0;
`endif

    assign rise     = message_ready && !msg_prev_q;
    assign full     = (cnt_q[side_q] == 4'(DEPTH));
    assign last_idx = full ? 4'(DEPTH - 1) : cnt_q[side_q];

    // Parallel compare: exact-price hit, and count of valid levels strictly better (= insert slot).
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        better  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (4'(i) < cnt_q[side_q]) begin
                if (price_q[side_q][i] == price_cap_q) begin
                    hit     = 1'b1;
                    hit_idx = 4'(i);
                end else if (side_q ? (price_q[side_q][i] < price_cap_q)
                                    : (price_q[side_q][i] > price_cap_q)) begin
                    better = better + 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        msg_prev_d      = message_ready;
        side_d          = side_q;
        act_d           = act_q;
        price_cap_d     = price_cap_q;
        qty_cap_d       = qty_cap_q;
        ord_cap_d       = ord_cap_q;
        idx_d           = idx_q;
        ptr_d           = ptr_q;
        price_d         = price_q;
        qty_d           = qty_q;
        ord_d           = ord_q;
        cnt_d           = cnt_q;
        top_bid_price_d = top_bid_price_q;
        top_bid_qty_d   = top_bid_qty_q;
        top_ask_price_d = top_ask_price_q;
        top_ask_qty_d   = top_ask_qty_q;
        updated_d       = 1'b0;
        dropped_d       = 1'b0;
        overrun_d       = rise && enable_order_book && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (rise && enable_order_book) begin
                    if (ACTION == 2'd3 || ENTRY_TYPE[1] || sec_reject) begin
                        dropped_d = 1'b1;
                    end else begin
                        side_d      = ENTRY_TYPE[0];
                        act_d       = ACTION;
                        price_cap_d = PRICE;
                        qty_cap_d   = QUANTITY;
                        ord_cap_d   = NUM_ORDERS;
                        state_d     = SCAN;
                    end
                end
            end
            SCAN: begin
                state_d = IDLE;
                case (act_q)
                    2'd0: begin
                        if (hit) begin
                            op_d    = OP_OVERWRITE;
                            idx_d   = hit_idx;
                            state_d = COMMIT;
                        end else if (full && better == 4'(DEPTH)) begin
                            dropped_d = 1'b1;
                        end else begin
                            op_d    = OP_INSERT;
                            idx_d   = better;
                            ptr_d   = last_idx;
                            state_d = (last_idx == better) ? COMMIT : SHIFT;
                        end
                    end
                    2'd1: begin
                        if (hit) begin
                            op_d    = OP_OVERWRITE;
                            idx_d   = hit_idx;
                            state_d = COMMIT;
                        end else begin
                            dropped_d = 1'b1;
                        end
                    end
                    default: begin
                        if (hit) begin
                            op_d    = OP_REMOVE;
                            idx_d   = hit_idx;
                            ptr_d   = hit_idx;
                            state_d = (hit_idx == cnt_q[side_q] - 4'd1) ? COMMIT : SHIFT;
                        end else begin
                            dropped_d = 1'b1;
                        end
                    end
                endcase
            end
            SHIFT: begin
                // Inserts open the gap from the bottom upward; removes close it from the top downward.
                if (op_q == OP_INSERT) begin
                    for (int i = 1; i < DEPTH; i++) begin
                        if (4'(i) == ptr_q) begin
                            price_d[side_q][i] = price_q[side_q][i-1];
                            qty_d[side_q][i]   = qty_q[side_q][i-1];
                            ord_d[side_q][i]   = ord_q[side_q][i-1];
                        end
                    end
                    ptr_d = ptr_q - 4'd1;
                    if (ptr_q == idx_q + 4'd1) state_d = COMMIT;
                end else begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        if (4'(i) == ptr_q) begin
                            price_d[side_q][i] = price_q[side_q][i+1];
                            qty_d[side_q][i]   = qty_q[side_q][i+1];
                            ord_d[side_q][i]   = ord_q[side_q][i+1];
                        end
                    end
                    ptr_d = ptr_q + 4'd1;
                    if (ptr_q + 4'd1 == cnt_q[side_q] - 4'd1) state_d = COMMIT;
                end
            end
            COMMIT: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (4'(i) == idx_q && op_q != OP_REMOVE) begin
                        qty_d[side_q][i] = qty_cap_q;
                        ord_d[side_q][i] = ord_cap_q;
                        if (op_q == OP_INSERT) price_d[side_q][i] = price_cap_q;
                    end
                end
                if (op_q == OP_INSERT && !full) cnt_d[side_q] = cnt_q[side_q] + 4'd1;
                if (op_q == OP_REMOVE)          cnt_d[side_q] = cnt_q[side_q] - 4'd1;
                updated_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q == COMMIT) begin
            top_bid_price_d = (cnt_d[0] != 4'd0) ? price_d[0][0] : 64'd0;
            top_bid_qty_d   = (cnt_d[0] != 4'd0) ? qty_d[0][0]   : 16'd0;
            top_ask_price_d = (cnt_d[1] != 4'd0) ? price_d[1][0] : 64'd0;
            top_ask_qty_d   = (cnt_d[1] != 4'd0) ? qty_d[1][0]   : 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            op_q            <= OP_OVERWRITE;
            msg_prev_q      <= 1'b0;
            side_q          <= 1'b0;
            act_q           <= 2'd0;
            price_cap_q     <= '0;
            qty_cap_q       <= '0;
            ord_cap_q       <= '0;
            idx_q           <= '0;
            ptr_q           <= '0;
            for (int s = 0; s < 2; s++) begin
                cnt_q[s] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    price_q[s][i] <= '0;
                    qty_q[s][i]   <= '0;
                    ord_q[s][i]   <= '0;
                end
            end
            top_bid_price_q <= '0;
            top_bid_qty_q   <= '0;
            top_ask_price_q <= '0;
            top_ask_qty_q   <= '0;
            updated_q       <= 1'b0;
            dropped_q       <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            msg_prev_q      <= msg_prev_d;
            side_q          <= side_d;
            act_q           <= act_d;
            price_cap_q     <= price_cap_d;
            qty_cap_q       <= qty_cap_d;
            ord_cap_q       <= ord_cap_d;
            idx_q           <= idx_d;
            ptr_q           <= ptr_d;
            price_q         <= price_d;
            qty_q           <= qty_d;
            ord_q           <= ord_d;
            cnt_q           <= cnt_d;
            top_bid_price_q <= top_bid_price_d;
            top_bid_qty_q   <= top_bid_qty_d;
            top_ask_price_q <= top_ask_price_d;
            top_ask_qty_q   <= top_ask_qty_d;
            updated_q       <= updated_d;
            dropped_q       <= dropped_d;
            overrun_q       <= overrun_d;
        end
    end

    assign TOP_BID_PRICE = top_bid_price_q;
    assign TOP_BID_QTY   = top_bid_qty_q;
    assign TOP_ASK_PRICE = top_ask_price_q;
    assign TOP_ASK_QTY   = top_ask_qty_q;
    assign bid_count     = cnt_q[0];
    assign ask_count     = cnt_q[1];
    assign book_busy     = (state_q != IDLE);
    assign book_updated  = updated_q;
    assign dropped       = dropped_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_mdp3_book_builder.sv
// Scoreboarded bench for mdp3_book_builder: stimulus pushes the expected pulse (kind, cycle, book tops),
// a negedge monitor pops and compares whenever book_updated, dropped or overrun fires.
module tb_mdp3_book_builder;

    localparam logic [1:0] NEW = 2'd0, CHG = 2'd1, DEL = 2'd2;
    localparam logic [1:0] BID = 2'd0, ASK = 2'd1;

    typedef struct {
        logic [2:0]  kind;
        int          cyc;
        logic [63:0] tbp;
        logic [15:0] tbq;
        logic [63:0] tap;
        logic [15:0] taq;
        logic [3:0]  bc;
        logic [3:0]  ac;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        message_ready = 1'b0;
    logic        enable_order_book = 1'b1;
    logic [7:0]  NUM_ORDERS = '0;
    logic [15:0] QUANTITY = '0;
    logic [63:0] PRICE = '0;
    logic [1:0]  ACTION = '0;
    logic [1:0]  ENTRY_TYPE = '0;
    logic [31:0] SECURITY_ID = 32'd7;
    logic [63:0] TOP_BID_PRICE, TOP_ASK_PRICE;
    logic [15:0] TOP_BID_QTY, TOP_ASK_QTY;
    logic [3:0]  bid_count, ask_count;
    logic        book_busy, book_updated, dropped, overrun;

    exp_t sb[$];
    exp_t monExp;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] secId = 32'd7;

    mdp3_book_builder #(.DEPTH(4), .TRACKED_SECURITY_ID(32'd7)) dut (
        .clk(clk), .reset(reset), .message_ready(message_ready),
        .enable_order_book(enable_order_book), .NUM_ORDERS(NUM_ORDERS),
        .QUANTITY(QUANTITY), .PRICE(PRICE), .ACTION(ACTION),
        .ENTRY_TYPE(ENTRY_TYPE), .SECURITY_ID(SECURITY_ID),
        .TOP_BID_PRICE(TOP_BID_PRICE), .TOP_BID_QTY(TOP_BID_QTY),
        .TOP_ASK_PRICE(TOP_ASK_PRICE), .TOP_ASK_QTY(TOP_ASK_QTY),
        .bid_count(bid_count), .ask_count(ask_count), .book_busy(book_busy),
        .book_updated(book_updated), .dropped(dropped), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic exp_t upd(input logic [63:0] bp, input logic [15:0] bq, input logic [63:0] ap,
                                 input logic [15:0] aq, input logic [3:0] bc, input logic [3:0] ac);
        exp_t e;
        e.kind = 3'b100; e.cyc = 0;
        e.tbp = bp; e.tbq = bq; e.tap = ap; e.taq = aq; e.bc = bc; e.ac = ac;
        return e;
    endfunction

    function automatic exp_t pulseOnly(input logic [2:0] kind);
        exp_t e;
        e = upd(0, 0, 0, 0, 0, 0);
        e.kind = kind;
        return e;
    endfunction

    // Monitor: every output pulse must match the oldest outstanding expectation, including its cycle.
    always @(negedge clk) begin
        if (reset && (book_updated || dropped || overrun)) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", {61'd0, book_updated, dropped, overrun}, 64'd0);
            end else begin
                monExp = sb.pop_front();
                checkOutput("pulse_kind", {61'd0, book_updated, dropped, overrun}, {61'd0, monExp.kind});
                checkOutput("pulse_cycle", cyc, monExp.cyc);
                if (monExp.kind[2]) begin
                    checkOutput("top_bid_price", TOP_BID_PRICE, monExp.tbp);
                    checkOutput("top_bid_qty", TOP_BID_QTY, monExp.tbq);
                    checkOutput("top_ask_price", TOP_ASK_PRICE, monExp.tap);
                    checkOutput("top_ask_qty", TOP_ASK_QTY, monExp.taq);
                    checkOutput("bid_count", bid_count, monExp.bc);
                    checkOutput("ask_count", ask_count, monExp.ac);
                end
            end
        end
    end

    task automatic drainScoreboard(input int settle);
        int waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", sb.size(), 64'd0);
            sb.delete();
        end
        repeat (settle) @(negedge clk);
    endtask

    task automatic driveFields(input logic [1:0] act, input logic [1:0] et, input logic [63:0] price,
                               input logic [15:0] qty);
        ACTION      = act;
        ENTRY_TYPE  = et;
        PRICE       = price;
        QUANTITY    = qty;
        NUM_ORDERS  = qty[7:0] + 8'd1;
        SECURITY_ID = secId;
    endtask

    task automatic applyStimulus(input logic [1:0] act, input logic [1:0] et, input logic [63:0] price,
                                 input logic [15:0] qty, input int holdCycles, input int latency,
                                 input exp_t e);
        @(negedge clk);
        driveFields(act, et, price, qty);
        message_ready = 1'b1;
        if (e.kind != 3'b000) begin
            e.cyc = cyc + latency;
            sb.push_back(e);
        end
        repeat (holdCycles) @(negedge clk);
        message_ready = 1'b0;
        drainScoreboard(2);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_bid_count", bid_count, 64'd0);
        checkOutput("reset_ask_count", ask_count, 64'd0);
        checkOutput("reset_top_bid", TOP_BID_PRICE, 64'd0);
        checkOutput("reset_top_ask_qty", TOP_ASK_QTY, 64'd0);
        checkOutput("reset_busy", book_busy, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Bid side build-up, overwrite, full-side insert and drop paths.
        applyStimulus(NEW, BID, 64'd100, 16'd5, 1, 3, upd(100, 5, 0, 0, 1, 0));
        applyStimulus(NEW, BID, 64'd80,  16'd3, 1, 3, upd(100, 5, 0, 0, 2, 0));
        applyStimulus(NEW, BID, 64'd90,  16'd4, 1, 4, upd(100, 5, 0, 0, 3, 0));
        applyStimulus(NEW, BID, 64'd95,  16'd7, 1, 5, upd(100, 5, 0, 0, 4, 0));
        applyStimulus(NEW, BID, 64'd110, 16'd9, 1, 6, upd(110, 9, 0, 0, 4, 0));
        applyStimulus(NEW, BID, 64'd90,  16'd2, 1, 3, upd(110, 9, 0, 0, 4, 0));
        applyStimulus(NEW, BID, 64'd50,  16'd1, 1, 2, pulseOnly(3'b010));
        applyStimulus(CHG, BID, 64'd110, 16'd20, 1, 3, upd(110, 20, 0, 0, 4, 0));
        applyStimulus(CHG, BID, 64'd111, 16'd1, 1, 2, pulseOnly(3'b010));

        // Ask side: ascending order, full-side worse drop and better insert.
        applyStimulus(NEW, ASK, 64'd12, 16'd1, 1, 3, upd(110, 20, 12, 1, 4, 1));
        applyStimulus(NEW, ASK, 64'd10, 16'd2, 1, 4, upd(110, 20, 10, 2, 4, 2));
        applyStimulus(NEW, ASK, 64'd13, 16'd3, 1, 3, upd(110, 20, 10, 2, 4, 3));
        applyStimulus(NEW, ASK, 64'd11, 16'd4, 1, 5, upd(110, 20, 10, 2, 4, 4));
        applyStimulus(NEW, ASK, 64'd14, 16'd1, 1, 2, pulseOnly(3'b010));
        applyStimulus(NEW, ASK, 64'd9,  16'd5, 1, 6, upd(110, 20, 9, 5, 4, 4));

        // Deletes down to an empty ask side.
        applyStimulus(DEL, ASK, 64'd9,  16'd0, 1, 6, upd(110, 20, 10, 2, 4, 3));
        applyStimulus(DEL, ASK, 64'd12, 16'd0, 1, 3, upd(110, 20, 10, 2, 4, 2));
        applyStimulus(DEL, ASK, 64'd10, 16'd0, 1, 4, upd(110, 20, 11, 4, 4, 1));
        applyStimulus(DEL, ASK, 64'd50, 16'd0, 1, 2, pulseOnly(3'b010));
        applyStimulus(DEL, ASK, 64'd11, 16'd0, 1, 3, upd(110, 20, 0, 0, 4, 0));

        // Invalid action / entry type, then a gated-off message.
        applyStimulus(2'd3, BID, 64'd1, 16'd1, 1, 1, pulseOnly(3'b010));
        applyStimulus(NEW, 2'd2, 64'd1, 16'd1, 1, 1, pulseOnly(3'b010));
        enable_order_book = 1'b0;
        applyStimulus(NEW, BID, 64'd1, 16'd1, 1, 0, pulseOnly(3'b000));
        enable_order_book = 1'b1;

        // Level held high for six cycles yields a single update.
        applyStimulus(NEW, BID, 64'd105, 16'd1, 6, 5, upd(110, 20, 0, 0, 4, 0));

        // Second edge during SHIFT: overrun at T+3, first update still lands at T+6.
        @(negedge clk);
        driveFields(NEW, BID, 64'd120, 16'd6);
        message_ready = 1'b1;
        monExp = pulseOnly(3'b001);
        monExp.cyc = cyc + 3;
        sb.push_back(monExp);
        monExp = upd(120, 6, 0, 0, 4, 0);
        monExp.cyc = cyc + 6;
        sb.push_back(monExp);
        @(negedge clk); message_ready = 1'b0;
        @(negedge clk); message_ready = 1'b1;
        @(negedge clk); message_ready = 1'b0;
        drainScoreboard(2);

        // Reset asserted during SHIFT abandons the insert with no pulse afterwards.
        @(negedge clk);
        driveFields(NEW, BID, 64'd130, 16'd1);
        message_ready = 1'b1;
        @(negedge clk); message_ready = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        drainScoreboard(8);
        checkOutput("midreset_bid_count", bid_count, 64'd0);
        checkOutput("midreset_top_bid", TOP_BID_PRICE, 64'd0);
        checkOutput("midreset_top_bid_qty", TOP_BID_QTY, 64'd0);
        checkOutput("midreset_busy", book_busy, 64'd0);

        applyStimulus(NEW, ASK, 64'd15, 16'd2, 1, 3, upd(0, 0, 15, 2, 0, 1));

`ifdef BOOK_SECURITY_FILTER_EN
        secId = 32'd8;
        applyStimulus(NEW, BID, 64'd200, 16'd1, 1, 1, pulseOnly(3'b010));
        secId = 32'd7;
`endif

        drainScoreboard(4);
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
